// File: rtl/shift_add_mult_pkg.sv
// Shared types and defaults for the shift-add multiplier controller.
package shift_add_mult_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/shift_add_mult_ctrl_add_unit.sv
// Single WIDTH-bit adder with carry-out; the controller reuses it every iteration.
module add_unit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Zero-extend both operands so the carry lands in the top bit.
  assign {cout, sum} = {1'b0, x} + {1'b0, y};

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned WIDTH x WIDTH multiplier: one adder, WIDTH shift-add iterations.
module shift_add_mult_ctrl
  import shift_add_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int              CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplr;
  logic [2*WIDTH:0]   acc;     // {carry, acc_hi, acc_lo}
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic [WIDTH:0]     hi_nxt;
  logic [2*WIDTH:0]   acc_nxt;

  add_unit #(.WIDTH(WIDTH)) u_add (
    .x    (acc[2*WIDTH-1:WIDTH]),
    .y    (mcand),
    .sum  (sum),
    .cout (cout)
  );

  // One iteration: conditionally add mcand into the high half, then shift right.
  always_comb begin
    hi_nxt  = mplr[0] ? {cout, sum} : acc[2*WIDTH:WIDTH];
    acc_nxt = {hi_nxt, acc[WIDTH-1:0]} >> 1;
  end

  // Controller FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplr    <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= a;
            mplr  <= b;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          acc   <= '0;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          acc  <= acc_nxt;
          mplr <= mplr >> 1;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            // Load from the final iteration's result so product is valid with done.
            product <= acc_nxt[2*WIDTH-1:0];
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
